// File: rtl/coeff_loader.sv
// Coefficient-load controller: buffers host coefficient words in a small FIFO,
// waits for a sample boundary, then streams them into the FIR coefficient SRAM
// one word per cycle, reporting done / error back to the host.
module coeff_loader #(
   parameter int unsigned NUM_TAPS_MAX = 40,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                  iClk12M,
   input  logic                  iRst,
   input  logic                  iEnSample600k,
   input  logic                  iLoadStart,
   input  logic [5:0]            iLoadNum,
   input  logic                  iAbort,
   input  logic                  iCoeffValid,
   input  logic [DATA_WIDTH-1:0] iCoeffData,
   output logic                  oCoeffReady,
   output logic                  oCoeffUpdateFlag,
   output logic [5:0]            oAddrRam,
   output logic [DATA_WIDTH-1:0] oWrDtRam,
   output logic                  oCoeffWrEn,
   output logic [5:0]            oNumOfCoeff,
   output logic                  oBusy,
   output logic                  oDone,
   output logic                  oErr
);

   localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW    = AddrW + 1;
   localparam logic [5:0]  MaxTaps = 6'(NUM_TAPS_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StWaitSlot,
      StLoad,
      StFlush,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [5:0]            n_q, n_d;
   logic [5:0]            acc_q, acc_d;
   logic [5:0]            wr_q, wr_d;
   logic [PtrW-1:0]       wptr_q, wptr_d;
   logic [PtrW-1:0]       rptr_q, rptr_d;
   logic                  flag_q, flag_d;
   logic [5:0]            addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wrdt_q, wrdt_d;
   logic                  wren_q, wren_d;
   logic [5:0]            num_q, num_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  coeff_ready;
   logic                  push;
   logic                  load_num_ok;
   logic [DATA_WIDTH-1:0] rd_data;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign fifo_empty  = (wptr_q == rptr_q);
   assign fifo_full   = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                        (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
   assign rd_data     = fifo_mem[rptr_q[AddrW-1:0]];

   // Ready depends on registered state only, never on iCoeffValid.
   assign coeff_ready = ((state_q == StWaitSlot) || (state_q == StLoad)) &&
                        !fifo_full && (acc_q < n_q);
   assign push        = iCoeffValid && coeff_ready;
   assign load_num_ok = (iLoadNum != 6'd0) && (iLoadNum <= MaxTaps);

   // FIFO storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge iClk12M) begin
      if (push) begin
         fifo_mem[wptr_q[AddrW-1:0]] <= iCoeffData;
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      acc_d   = acc_q;
      wr_d    = wr_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      flag_d  = flag_q;
      addr_d  = addr_q;
      wrdt_d  = wrdt_q;
      wren_d  = 1'b0;
      num_d   = num_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      if (push) begin
         wptr_d = wptr_q + PtrW'(1);
         acc_d  = acc_q + 6'd1;
      end

      if (iAbort && ((state_q == StWaitSlot) || (state_q == StLoad) ||
                     (state_q == StDone))) begin
         state_d = StFlush;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (iLoadStart) begin
                  if (load_num_ok) begin
                     state_d = StWaitSlot;
                     n_d     = iLoadNum;
                     acc_d   = 6'd0;
                     wr_d    = 6'd0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StWaitSlot: begin
               if (iEnSample600k) begin
                  state_d = StLoad;
                  flag_d  = 1'b1;
               end
            end
            StLoad: begin
               if (wr_q == n_q) begin
                  state_d = StDone;
               end else if (!fifo_empty) begin
                  rptr_d = rptr_q + PtrW'(1);
                  addr_d = wr_q;
                  wrdt_d = rd_data;
                  wren_d = 1'b1;
                  wr_d   = wr_q + 6'd1;
               end
            end
            StDone: begin
               // Flag was held through this cycle so the last SRAM write lands.
               state_d = StIdle;
               flag_d  = 1'b0;
               num_d   = n_q;
               done_d  = 1'b1;
            end
            StFlush: begin
               state_d = StIdle;
               flag_d  = 1'b0;
               err_d   = 1'b1;
               wptr_d  = '0;
               rptr_d  = '0;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         state_q <= StIdle;
         n_q     <= '0;
         acc_q   <= '0;
         wr_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         flag_q  <= 1'b0;
         addr_q  <= '0;
         wrdt_q  <= '0;
         wren_q  <= 1'b0;
         num_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         wr_q    <= wr_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         flag_q  <= flag_d;
         addr_q  <= addr_d;
         wrdt_q  <= wrdt_d;
         wren_q  <= wren_d;
         num_q   <= num_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign oCoeffReady      = coeff_ready;
   assign oCoeffUpdateFlag = flag_q;
   assign oAddrRam         = addr_q;
   assign oWrDtRam         = wrdt_q;
   assign oCoeffWrEn       = wren_q;
   assign oNumOfCoeff      = num_q;
   assign oBusy            = (state_q != StIdle);
   assign oDone            = done_q;
   assign oErr             = err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: table of load counts plus hand-written
// multi-cycle sequences (basic, abort, gappy host, backpressure, reset).
module tb_coeff_loader;

   logic        clk = 1'b0;
   logic        iRst = 1'b0;
   logic        iEnSample600k = 1'b0;
   logic        iLoadStart = 1'b0;
   logic [5:0]  iLoadNum = '0;
   logic        iAbort = 1'b0;
   logic        iCoeffValid = 1'b0;
   logic [15:0] iCoeffData = '0;
   logic        oCoeffReady;
   logic        oCoeffUpdateFlag;
   logic [5:0]  oAddrRam;
   logic [15:0] oWrDtRam;
   logic        oCoeffWrEn;
   logic [5:0]  oNumOfCoeff;
   logic        oBusy;
   logic        oDone;
   logic        oErr;

   always #5 clk = ~clk;

   coeff_loader #(
      .NUM_TAPS_MAX(40),
      .DATA_WIDTH  (16),
      .FIFO_DEPTH  (8)
   ) dut (
      .iClk12M         (clk),
      .iRst            (iRst),
      .iEnSample600k   (iEnSample600k),
      .iLoadStart      (iLoadStart),
      .iLoadNum        (iLoadNum),
      .iAbort          (iAbort),
      .iCoeffValid     (iCoeffValid),
      .iCoeffData      (iCoeffData),
      .oCoeffReady     (oCoeffReady),
      .oCoeffUpdateFlag(oCoeffUpdateFlag),
      .oAddrRam        (oAddrRam),
      .oWrDtRam        (oWrDtRam),
      .oCoeffWrEn      (oCoeffWrEn),
      .oNumOfCoeff     (oNumOfCoeff),
      .oBusy           (oBusy),
      .oDone           (oDone),
      .oErr            (oErr)
   );

   typedef struct {
      logic [5:0]  addr;
      logic [15:0] data;
      int          cyc;
   } strobe_t;

   typedef struct {
      logic [5:0] num;
      logic       exp_err;
      logic       exp_busy;
   } vec_t;

   strobe_t q[$];
   int nchk = 0;
   int nerr = 0;
   int cycle = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int sent = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // One clock; outputs sampled 1 ns after the edge, strobes logged.
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      if (oCoeffWrEn === 1'b1) q.push_back('{oAddrRam, oWrDtRam, cycle});
      if (oDone === 1'b1) done_cnt++;
      if (oErr === 1'b1) err_cnt++;
   endtask

   task automatic start_load(input logic [5:0] n);
      iLoadStart = 1'b1;
      iLoadNum   = n;
      tick();
      iLoadStart = 1'b0;
   endtask

   // One host cycle: offer word 'sent' of the set if val, optional sample strobe.
   task automatic cyc(input bit val, input bit smp, input logic [5:0] n, input logic [15:0] base);
      bit hs;
      iCoeffValid   = val && (sent < int'(n));
      iCoeffData    = base + 16'(sent);
      iEnSample600k = smp;
      hs = iCoeffValid && oCoeffReady;
      tick();
      iEnSample600k = 1'b0;
      iCoeffValid   = 1'b0;
      if (hs) sent++;
   endtask

   task automatic run_until_done(input logic [5:0] n, input logic [15:0] base, input int max);
      int k = 0;
      while (!oDone && k < max) begin
         cyc(1'b1, 1'b0, n, base);
         k++;
      end
      chk("done_reached", 32'(oDone), 32'd1);
   endtask

   task automatic check_strobes(input int n, input logic [15:0] base);
      chk("strobe_count", 32'(q.size()), 32'(n));
      for (int i = 0; i < q.size() && i < n; i++) begin
         chk("strobe_addr", 32'(q[i].addr), 32'(i));
         chk("strobe_data", 32'(q[i].data), 32'(base + 16'(i)));
      end
   endtask

   initial begin
      vec_t        vecs[5];
      logic [15:0] w[4];
      int          k;
      int          bad;
      int          bad_flag;
      int          dc;
      int          ec;

      vecs[0] = '{6'd0,  1'b1, 1'b0};
      vecs[1] = '{6'd41, 1'b1, 1'b0};
      vecs[2] = '{6'd63, 1'b1, 1'b0};
      vecs[3] = '{6'd1,  1'b0, 1'b1};
      vecs[4] = '{6'd40, 1'b0, 1'b1};
      w[0] = 16'h0001; w[1] = 16'h0002; w[2] = 16'hFFFF; w[3] = 16'h7FFF;

      // Reset state
      iRst = 1'b1;
      tick();
      tick();
      iRst = 1'b0;
      chk("rst_flag", 32'(oCoeffUpdateFlag), 0);
      chk("rst_addr", 32'(oAddrRam), 0);
      chk("rst_data", 32'(oWrDtRam), 0);
      chk("rst_wren", 32'(oCoeffWrEn), 0);
      chk("rst_num", 32'(oNumOfCoeff), 0);
      chk("rst_busy", 32'(oBusy), 0);
      chk("rst_done", 32'(oDone), 0);
      chk("rst_err", 32'(oErr), 0);
      chk("rst_ready", 32'(oCoeffReady), 0);

      // Basic load of 4 words before the sample strobe
      start_load(6'd4);
      chk("basic_busy", 32'(oBusy), 1);
      chk("basic_ready", 32'(oCoeffReady), 1);
      q.delete();
      for (int i = 0; i < 4; i++) begin
         iCoeffValid = 1'b1;
         iCoeffData  = w[i];
         chk("basic_ready_stream", 32'(oCoeffReady), 1);
         tick();
      end
      iCoeffValid = 1'b0;
      chk("basic_ready_acc_full", 32'(oCoeffReady), 0);
      chk("basic_flag_wait", 32'(oCoeffUpdateFlag), 0);
      iEnSample600k = 1'b1;
      tick();
      iEnSample600k = 1'b0;
      chk("basic_flag_rise", 32'(oCoeffUpdateFlag), 1);
      chk("basic_no_wren_yet", 32'(oCoeffWrEn), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("basic_wren", 32'(oCoeffWrEn), 1);
         chk("basic_addr", 32'(oAddrRam), 32'(i));
         chk("basic_data", 32'(oWrDtRam), 32'(w[i]));
      end
      tick();
      chk("basic_c1_wren", 32'(oCoeffWrEn), 0);
      chk("basic_c1_flag", 32'(oCoeffUpdateFlag), 1);
      chk("basic_c1_busy", 32'(oBusy), 1);
      chk("basic_c1_done", 32'(oDone), 0);
      chk("basic_c1_addr_hold", 32'(oAddrRam), 3);
      tick();
      chk("basic_c2_flag", 32'(oCoeffUpdateFlag), 0);
      chk("basic_c2_done", 32'(oDone), 1);
      chk("basic_c2_num", 32'(oNumOfCoeff), 4);
      chk("basic_c2_busy", 32'(oBusy), 0);
      tick();
      chk("basic_done_pulse", 32'(oDone), 0);

      // Table: legal and illegal tap counts
      foreach (vecs[i]) begin
         start_load(vecs[i].num);
         chk("tbl_err", 32'(oErr), 32'(vecs[i].exp_err));
         chk("tbl_busy", 32'(oBusy), 32'(vecs[i].exp_busy));
         chk("tbl_ready", 32'(oCoeffReady), 32'(vecs[i].exp_busy));
         chk("tbl_num", 32'(oNumOfCoeff), 4);
         if (vecs[i].exp_busy) begin
            iAbort = 1'b1;
            tick();
            iAbort = 1'b0;
            tick();
            chk("tbl_abort_err", 32'(oErr), 1);
            chk("tbl_abort_busy", 32'(oBusy), 0);
         end
         tick();
         chk("tbl_err_pulse", 32'(oErr), 0);
         chk("tbl_idle", 32'(oBusy), 0);
      end

      // Abort after 7 strobes, then a clean reload
      start_load(6'd20);
      q.delete();
      sent = 0;
      cyc(1'b1, 1'b1, 6'd20, 16'h1000);
      k = 0;
      while (q.size() < 7 && k < 100) begin
         cyc(1'b1, 1'b0, 6'd20, 16'h1000);
         k++;
      end
      chk("abort_7_strobes", 32'(q.size()), 7);
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      tick();
      chk("abort_err", 32'(oErr), 1);
      chk("abort_flag", 32'(oCoeffUpdateFlag), 0);
      chk("abort_busy", 32'(oBusy), 0);
      chk("abort_num_kept", 32'(oNumOfCoeff), 4);
      chk("abort_ready", 32'(oCoeffReady), 0);
      check_strobes(7, 16'h1000);
      start_load(6'd3);
      q.delete();
      sent = 0;
      cyc(1'b1, 1'b1, 6'd3, 16'hA000);
      run_until_done(6'd3, 16'hA000, 50);
      check_strobes(3, 16'hA000);
      chk("reload_num", 32'(oNumOfCoeff), 3);

      // Gappy host: valid every third cycle
      start_load(6'd10);
      q.delete();
      sent = 0;
      bad = 0;
      bad_flag = 0;
      cyc(1'b1, 1'b1, 6'd10, 16'h3000);
      k = 1;
      while (!oDone && k < 200) begin
         cyc((k % 3) == 0, 1'b0, 6'd10, 16'h3000);
         if (q.size() > 0 && !oCoeffWrEn &&
             (oAddrRam !== q[$].addr || oWrDtRam !== q[$].data)) bad++;
         if (q.size() > 0 && !oDone && !oCoeffUpdateFlag) bad_flag++;
         k++;
      end
      chk("gappy_done", 32'(oDone), 1);
      chk("gappy_hold", 32'(bad), 0);
      chk("gappy_flag_high", 32'(bad_flag), 0);
      check_strobes(10, 16'h3000);
      for (int i = 1; i < q.size(); i++) begin
         chk("gappy_spacing", 32'(q[i].cyc - q[i-1].cyc), 3);
      end
      chk("gappy_num", 32'(oNumOfCoeff), 10);

      // Backpressure: 40 taps, sample strobe delayed 30 cycles
      start_load(6'd40);
      q.delete();
      sent = 0;
      for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 6'd40, 16'h2000);
      chk("bp_accepted", 32'(sent), 8);
      chk("bp_ready_full", 32'(oCoeffReady), 0);
      chk("bp_flag_wait", 32'(oCoeffUpdateFlag), 0);
      cyc(1'b1, 1'b1, 6'd40, 16'h2000);
      bad = 0;
      k = 0;
      while (!oDone && k < 200) begin
         cyc(1'b1, 1'b0, 6'd40, 16'h2000);
         if (sent == 40 && oCoeffReady) bad++;
         k++;
      end
      chk("bp_done", 32'(oDone), 1);
      chk("bp_ready_after_all", 32'(bad), 0);
      check_strobes(40, 16'h2000);
      chk("bp_num", 32'(oNumOfCoeff), 40);

      // Reset in the middle of a load
      start_load(6'd5);
      q.delete();
      sent = 0;
      cyc(1'b1, 1'b1, 6'd5, 16'h5000);
      k = 0;
      while (q.size() < 2 && k < 50) begin
         cyc(1'b1, 1'b0, 6'd5, 16'h5000);
         k++;
      end
      chk("mid_rst_in_load", 32'(oCoeffUpdateFlag), 1);
      dc = done_cnt;
      ec = err_cnt;
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      chk("mid_rst_flag", 32'(oCoeffUpdateFlag), 0);
      chk("mid_rst_addr", 32'(oAddrRam), 0);
      chk("mid_rst_data", 32'(oWrDtRam), 0);
      chk("mid_rst_wren", 32'(oCoeffWrEn), 0);
      chk("mid_rst_num", 32'(oNumOfCoeff), 0);
      chk("mid_rst_busy", 32'(oBusy), 0);
      chk("mid_rst_ready", 32'(oCoeffReady), 0);
      tick();
      tick();
      chk("mid_rst_no_done", 32'(done_cnt - dc), 0);
      chk("mid_rst_no_err", 32'(err_cnt - ec), 0);
      start_load(6'd2);
      q.delete();
      sent = 0;
      cyc(1'b1, 1'b1, 6'd2, 16'h6000);
      run_until_done(6'd2, 16'h6000, 50);
      check_strobes(2, 16'h6000);
      chk("mid_rst_reload_num", 32'(oNumOfCoeff), 2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
